// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Single-entry execute-issue slot directly upstream of the ALU. It takes one
// decoded instruction from decode, resolves operand forwarding from EX/MEM and
// MEM/WB, and drives the ALU opcode and operands.
//
// Optional feature macro: ALU_ISSUE_FWD_EN
//   defined   : forward-select on src1/src2 plus hold refresh of stored values
//   undefined : operands come straight from the slot, exmem_*/memwb_* ignored
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 drop slot contents and any offered instruction
//   in_valid_i/in_ready_o   decode-side handshake
//   in_*                    decoded instruction fields and register-file data
//   exmem_*, memwb_*        writeback info from later stages (forwarding)
//   out_valid_o/out_ready_i ALU-side handshake
//   op_o, src1_o, src2_o    ALU opcode and operands
//   rd_addr_o, reg_write_o  destination register and write enable
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps valid and payload stable until that edge;
// ready may depend combinationally on the consumer's ready (in_ready_o
// does), which lets the slot refill in the same cycle it drains.
// ---------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        in_alu_op_i,
   input  logic [REG_AW-1:0] in_rs1_addr_i,
   input  logic [REG_AW-1:0] in_rs2_addr_i,
   input  logic [DATA_W-1:0] in_rs1_data_i,
   input  logic [DATA_W-1:0] in_rs2_data_i,
   input  logic [DATA_W-1:0] in_imm_i,
   input  logic              in_use_imm_i,
   input  logic [REG_AW-1:0] in_rd_addr_i,
   input  logic              in_reg_write_i,
   input  logic              exmem_reg_write_i,
   input  logic [REG_AW-1:0] exmem_rd_addr_i,
   input  logic [DATA_W-1:0] exmem_result_i,
   input  logic              memwb_reg_write_i,
   input  logic [REG_AW-1:0] memwb_rd_addr_i,
   input  logic [DATA_W-1:0] memwb_result_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [2:0]        op_o,
   output logic [DATA_W-1:0] src1_o,
   output logic [DATA_W-1:0] src2_o,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic              reg_write_o
);

   // Slot registers
   logic              r_valid;
   logic [2:0]        r_op;
   logic [REG_AW-1:0] r_rs1_addr;
   logic [REG_AW-1:0] r_rs2_addr;
   logic [DATA_W-1:0] r_rs1_val;
   logic [DATA_W-1:0] r_rs2_val;
   logic              r_fwd2_en;   // src2 is a register (not the immediate)
   logic [REG_AW-1:0] r_rd;
   logic              r_reg_write;

   logic              w_accept;
   logic [DATA_W-1:0] w_src1;
   logic [DATA_W-1:0] w_src2;

   assign in_ready_o = !r_valid || out_ready_i;
   assign w_accept   = in_valid_i && in_ready_o && !flush_i;

   // Forward-select: EX/MEM is younger than MEM/WB so it wins; x0 is
   // hard-wired zero and is never forwarded.
   always_comb begin
      w_src1 = r_rs1_val;
      w_src2 = r_rs2_val;
`ifdef ALU_ISSUE_FWD_EN
      if (exmem_reg_write_i && (exmem_rd_addr_i == r_rs1_addr) && (r_rs1_addr != '0))
         w_src1 = exmem_result_i;
      else if (memwb_reg_write_i && (memwb_rd_addr_i == r_rs1_addr) && (r_rs1_addr != '0))
         w_src1 = memwb_result_i;
      if (r_fwd2_en) begin
         if (exmem_reg_write_i && (exmem_rd_addr_i == r_rs2_addr) && (r_rs2_addr != '0))
            w_src2 = exmem_result_i;
         else if (memwb_reg_write_i && (memwb_rd_addr_i == r_rs2_addr) && (r_rs2_addr != '0))
            w_src2 = memwb_result_i;
      end
`endif
   end

`ifndef ALU_ISSUE_FWD_EN
   // Forwarding inputs and source addresses have no function in this build.
   logic w_unused_fwd;
   assign w_unused_fwd = ^{exmem_reg_write_i, exmem_rd_addr_i, exmem_result_i,
                           memwb_reg_write_i, memwb_rd_addr_i, memwb_result_i,
                           r_rs1_addr, r_rs2_addr, r_fwd2_en};
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid     <= 1'b0;
         r_op        <= '0;
         r_rs1_addr  <= '0;
         r_rs2_addr  <= '0;
         r_rs1_val   <= '0;
         r_rs2_val   <= '0;
         r_fwd2_en   <= 1'b0;
         r_rd        <= '0;
         r_reg_write <= 1'b0;
      end else if (flush_i) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid     <= 1'b1;
         r_op        <= in_alu_op_i;
         r_rs1_addr  <= in_rs1_addr_i;
         r_rs2_addr  <= in_rs2_addr_i;
         r_rs1_val   <= in_rs1_data_i;
         r_rd        <= in_rd_addr_i;
         r_reg_write <= in_reg_write_i;
         if (in_use_imm_i) begin
            r_rs2_val <= in_imm_i;
            r_fwd2_en <= 1'b0;
         end else begin
            r_rs2_val <= in_rs2_data_i;
            r_fwd2_en <= 1'b1;
         end
      end else begin
         if (r_valid && out_ready_i)
            r_valid <= 1'b0;
`ifdef ALU_ISSUE_FWD_EN
         // While stalled, capture forwarded values so they survive the
         // producer leaving EX/MEM or MEM/WB.
         if (r_valid && !out_ready_i) begin
            r_rs1_val <= w_src1;
            r_rs2_val <= w_src2;
         end
`endif
      end
   end

   assign out_valid_o = r_valid;
   assign op_o        = r_op;
   assign src1_o      = w_src1;
   assign src2_o      = w_src2;
   assign rd_addr_o   = r_rd;
   assign reg_write_o = r_valid && r_reg_write;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. Expected values are hand-derived; the
// ones that depend on forwarding select between two constants with the same
// macro the design uses.
module tb_alu_issue_stage;
   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

`ifdef ALU_ISSUE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic              rst_i;
   logic              flush_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [2:0]        in_alu_op_i;
   logic [REG_AW-1:0] in_rs1_addr_i;
   logic [REG_AW-1:0] in_rs2_addr_i;
   logic [DATA_W-1:0] in_rs1_data_i;
   logic [DATA_W-1:0] in_rs2_data_i;
   logic [DATA_W-1:0] in_imm_i;
   logic              in_use_imm_i;
   logic [REG_AW-1:0] in_rd_addr_i;
   logic              in_reg_write_i;
   logic              exmem_reg_write_i;
   logic [REG_AW-1:0] exmem_rd_addr_i;
   logic [DATA_W-1:0] exmem_result_i;
   logic              memwb_reg_write_i;
   logic [REG_AW-1:0] memwb_rd_addr_i;
   logic [DATA_W-1:0] memwb_result_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [2:0]        op_o;
   logic [DATA_W-1:0] src1_o;
   logic [DATA_W-1:0] src2_o;
   logic [REG_AW-1:0] rd_addr_o;
   logic              reg_write_o;

   alu_issue_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_alu_op_i(in_alu_op_i),
      .in_rs1_addr_i(in_rs1_addr_i), .in_rs2_addr_i(in_rs2_addr_i),
      .in_rs1_data_i(in_rs1_data_i), .in_rs2_data_i(in_rs2_data_i),
      .in_imm_i(in_imm_i), .in_use_imm_i(in_use_imm_i),
      .in_rd_addr_i(in_rd_addr_i), .in_reg_write_i(in_reg_write_i),
      .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_addr_i(exmem_rd_addr_i),
      .exmem_result_i(exmem_result_i),
      .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_addr_i(memwb_rd_addr_i),
      .memwb_result_i(memwb_result_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .op_o(op_o), .src1_o(src1_o), .src2_o(src2_o),
      .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [DATA_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic offer(input logic [2:0] op,
                        input logic [REG_AW-1:0] rs1a, input logic [DATA_W-1:0] rs1d,
                        input logic [REG_AW-1:0] rs2a, input logic [DATA_W-1:0] rs2d,
                        input logic [DATA_W-1:0] imm, input logic use_imm,
                        input logic [REG_AW-1:0] rd, input logic rw);
      in_valid_i     = 1'b1;
      in_alu_op_i    = op;
      in_rs1_addr_i  = rs1a;
      in_rs1_data_i  = rs1d;
      in_rs2_addr_i  = rs2a;
      in_rs2_data_i  = rs2d;
      in_imm_i       = imm;
      in_use_imm_i   = use_imm;
      in_rd_addr_i   = rd;
      in_reg_write_i = rw;
   endtask

   task automatic set_exmem(input logic we, input logic [REG_AW-1:0] a,
                            input logic [DATA_W-1:0] d);
      exmem_reg_write_i = we;
      exmem_rd_addr_i   = a;
      exmem_result_i    = d;
   endtask

   task automatic set_memwb(input logic we, input logic [REG_AW-1:0] a,
                            input logic [DATA_W-1:0] d);
      memwb_reg_write_i = we;
      memwb_rd_addr_i   = a;
      memwb_result_i    = d;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
      offer(3'd0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
      in_valid_i = 1'b0;
      set_exmem(1'b0, '0, '0);
      set_memwb(1'b0, '0, '0);

      // Reset state
      tick(); tick();
      rst_i = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid_o), 32'd0);
      check("rst_op", 32'(op_o), 32'd0);
      check("rst_src1", src1_o, 32'd0);
      check("rst_src2", src2_o, 32'd0);
      check("rst_rd", 32'(rd_addr_o), 32'd0);
      check("rst_rw", 32'(reg_write_o), 32'd0);
      check("rst_in_ready", 32'(in_ready_o), 32'd1);

      // Basic transfer: ADD x1=5, x2=3 -> x7
      offer(3'd3, 5'd1, 32'h5, 5'd2, 32'h3, 32'h0, 1'b0, 5'd7, 1'b1);
      tick();
      in_valid_i = 1'b0;
      #1;
      check("add_valid", 32'(out_valid_o), 32'd1);
      check("add_op", 32'(op_o), 32'd3);
      check("add_src1", src1_o, 32'h5);
      check("add_src2", src2_o, 32'h3);
      check("add_rw", 32'(reg_write_o), 32'd1);
      check("add_rd", 32'(rd_addr_o), 32'd7);
      check("add_in_ready", 32'(in_ready_o), 32'd0);

      // Hold refresh: exmem hits x1 for one cycle, then idle three cycles.
      // A competing offer must be dropped while the slot is stalled.
      offer(3'd0, 5'd1, 32'h99, 5'd2, 32'h98, 32'h0, 1'b0, 5'd9, 1'b1);
      set_exmem(1'b1, 5'd1, 32'h1234);
      #1;
      check("hold_fwd_src1", src1_o, FWD ? 32'h1234 : 32'h5);
      check("hold_in_ready0", 32'(in_ready_o), 32'd0);
      tick();
      set_exmem(1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("hold_src1", src1_o, FWD ? 32'h1234 : 32'h5);
         check("hold_in_ready", 32'(in_ready_o), 32'd0);
         check("hold_op", 32'(op_o), 32'd3);
         tick();
      end
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      #1;
      check("consume_in_ready", 32'(in_ready_o), 32'd1);
      tick();
      out_ready_i = 1'b0;
      #1;
      check("empty_valid", 32'(out_valid_o), 32'd0);
      check("empty_rw", 32'(reg_write_o), 32'd0);
      check("empty_keep_src1", src1_o, FWD ? 32'h1234 : 32'h5);

      // Immediate: ADDI, exmem writes rs2's register but imm must win
      offer(3'd6, 5'd3, 32'h10, 5'd9, 32'h77, 32'hFFFF_FFF0, 1'b1, 5'd8, 1'b1);
      set_exmem(1'b1, 5'd9, 32'hDEAD);
      tick();
      in_valid_i = 1'b0;
      #1;
      check("imm_src2", src2_o, 32'hFFFF_FFF0);
      check("imm_src1", src1_o, 32'h10);
      check("imm_op", 32'(op_o), 32'd6);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      set_exmem(1'b0, 5'd0, 32'h0);

      // x0 is never forwarded
      offer(3'd3, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd1, 1'b1);
      tick();
      in_valid_i = 1'b0;
      set_exmem(1'b1, 5'd0, 32'h55);
      set_memwb(1'b1, 5'd0, 32'h66);
      #1;
      check("x0_src1", src1_o, 32'h0);
      check("x0_src2", src2_o, 32'h0);
      set_exmem(1'b0, 5'd0, 32'h0);
      set_memwb(1'b0, 5'd0, 32'h0);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;

      // Forward priority: x4 stored 0x11, exmem 0xAA beats memwb 0xBB
      offer(3'd4, 5'd4, 32'h11, 5'd5, 32'h22, 32'h0, 1'b0, 5'd6, 1'b1);
      tick();
      in_valid_i = 1'b0;
      set_exmem(1'b1, 5'd4, 32'hAA);
      set_memwb(1'b1, 5'd4, 32'hBB);
      #1;
      check("prio_exmem", src1_o, FWD ? 32'hAA : 32'h11);
      set_exmem(1'b0, 5'd4, 32'hAA);
      #1;
      check("prio_memwb", src1_o, FWD ? 32'hBB : 32'h11);
      set_memwb(1'b1, 5'd5, 32'hCC);
      #1;
      check("fwd_src2_memwb", src2_o, FWD ? 32'hCC : 32'h22);
      check("fwd_src1_none", src1_o, 32'h11);
      set_memwb(1'b0, 5'd0, 32'h0);
      out_ready_i = 1'b1;
      tick();

      // Back-to-back: three instructions on consecutive cycles
      for (int i = 0; i < 3; i++) begin
         offer(3'(i), 5'd1, 32'hA0 + 32'(i), 5'd2, 32'hB0, 32'h0, 1'b0, 5'(i + 1), 1'b1);
         exp_q.push_back(32'hA0 + 32'(i));
         tick();
         #1;
         check("b2b_valid", 32'(out_valid_o), 32'd1);
         check("b2b_src1", src1_o, exp_q.pop_front());
         check("b2b_rd", 32'(rd_addr_o), 32'(i + 1));
      end
      in_valid_i = 1'b0;
      tick();
      check("b2b_drain_valid", 32'(out_valid_o), 32'd0);

      // Flush together with an offered instruction
      out_ready_i = 1'b0;
      offer(3'd3, 5'd1, 32'hD1, 5'd2, 32'hD2, 32'h0, 1'b0, 5'd3, 1'b1);
      tick();
      offer(3'd1, 5'd1, 32'hE1, 5'd2, 32'hE2, 32'h0, 1'b0, 5'd4, 1'b1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      #1;
      check("flush_valid", 32'(out_valid_o), 32'd0);
      check("flush_rw", 32'(reg_write_o), 32'd0);
      check("flush_dropped", src1_o, 32'hD1);
      check("flush_in_ready", 32'(in_ready_o), 32'd1);

      // Reset while held clears the slot
      offer(3'd5, 5'd1, 32'hF1, 5'd2, 32'hF2, 32'h0, 1'b0, 5'd5, 1'b1);
      tick();
      in_valid_i = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      check("rst_hold_valid", 32'(out_valid_o), 32'd0);
      check("rst_hold_src1", src1_o, 32'h0);
      check("rst_hold_rd", 32'(rd_addr_o), 32'd0);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
